// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its BTB.
package fetch_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC    = 64'h0;
  localparam int          DEFAULT_BTB_ENTRIES = 16;
  localparam logic [63:0] DEFAULT_NOP_INSTR   = 64'h0;
  localparam logic [63:0] INSTR_BYTES         = 64'd8;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] instr;
    logic        predicted_taken;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// Handshake: req/addr are presented each cycle with no outstanding transactions;
// ack in a cycle means rdata holds the word at that same cycle's addr.
interface fetch_if;
  logic        ibus_req_out;
  logic [63:0] ibus_addr_out;
  logic        ibus_ack_in;
  logic [63:0] ibus_rdata_in;

  modport master (output ibus_req_out, ibus_addr_out, input ibus_ack_in, ibus_rdata_in);
  modport slave  (input ibus_req_out, ibus_addr_out, output ibus_ack_in, ibus_rdata_in);
endinterface

// File: rtl/fetch_branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, synchronous allocate/train update.
module branch_target_buffer
  import fetch_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] lookup_pc,
  output logic        lookup_taken,
  output logic [63:0] lookup_target,
  input  logic        update_en,
  input  logic [63:0] update_pc,
  input  logic [63:0] update_target,
  input  logic        update_taken
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 64 - 3 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [63:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_match;
  logic             unused_low_bits;

  // Instructions are 8-byte aligned, so the low three address bits carry no information.
  assign unused_low_bits = ^{lookup_pc[2:0], update_pc[2:0]};

  assign l_idx = lookup_pc[3 +: IDX_W];
  assign l_tag = lookup_pc[63 -: TAG_W];
  assign u_idx = update_pc[3 +: IDX_W];
  assign u_tag = update_pc[63 -: TAG_W];

  always_comb begin
    lookup_taken  = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && ctr_q[l_idx][1];
    lookup_target = target_q[l_idx];
    u_match       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update_en) begin
      if (!u_match) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target;
        ctr_q[u_idx]    <= update_taken ? 2'b10 : 2'b01;
      end else if (update_taken) begin
        target_q[u_idx] <= update_target;
        if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
      end else begin
        if (ctr_q[u_idx] != 2'b00) ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, FETCH/HOLD state machine, one-entry
// hold buffer and registered decode outputs, with BTB next-PC prediction.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          BTB_ENTRIES = DEFAULT_BTB_ENTRIES,
  parameter logic [63:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_in,
  input  logic          flush_in,
  input  logic          redirect_in,
  input  logic [63:0]   redirect_pc_in,
  input  logic          btb_update_in,
  input  logic [63:0]   btb_update_pc_in,
  input  logic [63:0]   btb_update_target_in,
  input  logic          btb_update_taken_in,
  fetch_if.master       ibus,
  output logic          valid_out,
  output logic [63:0]   pc_out,
  output logic [63:0]   instr_out,
  output logic          branch_predicted_taken_out,
  output fetch_state_e  dbg_state
);
  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d, next_pc, pred_target;
  logic         pred_taken;
  fetch_pkt_t   hold_q, hold_d, out_q, out_d, bus_pkt, bubble_pkt;
  logic         valid_q, valid_d;

  branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (pc_q),
    .lookup_taken  (pred_taken),
    .lookup_target (pred_target),
    .update_en     (btb_update_in),
    .update_pc     (btb_update_pc_in),
    .update_target (btb_update_target_in),
    .update_taken  (btb_update_taken_in)
  );

  assign ibus.ibus_req_out  = rst_n && (state_q == FETCH);
  assign ibus.ibus_addr_out = pc_q;

  always_comb begin
    next_pc    = pred_taken ? pred_target : pc_q + INSTR_BYTES;
    bus_pkt    = '{pc: pc_q, instr: ibus.ibus_rdata_in, predicted_taken: pred_taken};
    bubble_pkt = '{pc: out_q.pc, instr: NOP_INSTR, predicted_taken: 1'b0};
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    out_d      = out_q;
    valid_d    = valid_q;

    if (redirect_in) begin
      // Redirect wins: any same-cycle ack and any parked word are dropped.
      pc_d    = redirect_pc_in;
      state_d = FETCH;
      if (!stall_in) begin
        out_d   = bubble_pkt;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ibus.ibus_ack_in) begin
            pc_d = next_pc;
            if (stall_in) begin
              hold_d  = bus_pkt;
              state_d = HOLD;
            end else begin
              out_d   = flush_in ? bubble_pkt : bus_pkt;
              valid_d = !flush_in;
            end
          end else if (!stall_in) begin
            out_d   = bubble_pkt;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            out_d   = flush_in ? bubble_pkt : hold_q;
            valid_d = !flush_in;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      out_q   <= '{pc: 64'h0, instr: NOP_INSTR, predicted_taken: 1'b0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out                  = valid_q;
  assign pc_out                     = out_q.pc;
  assign instr_out                  = out_q.instr;
  assign branch_predicted_taken_out = out_q.predicted_taken;
  assign dbg_state                  = state_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios then random traffic, checked against a
// cycle-level behavioural model of the fetch rules and BTB.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] NOP   = 64'h0000_0000_0000_0013;
  localparam int          BTB_N = 16;
  localparam int          LOG_N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall_in = 1'b0, flush_in = 1'b0, redirect_in = 1'b0;
  logic [63:0]  redirect_pc_in = '0;
  logic         btb_update_in = 1'b0, btb_update_taken_in = 1'b0;
  logic [63:0]  btb_update_pc_in = '0, btb_update_target_in = '0;
  logic         valid_out, branch_predicted_taken_out;
  logic [63:0]  pc_out, instr_out;
  fetch_state_e dbg_state;

  fetch_if ibus ();

  fetch #(.RESET_PC(64'h0), .BTB_ENTRIES(BTB_N), .NOP_INSTR(NOP)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .redirect_in                (redirect_in),
    .redirect_pc_in             (redirect_pc_in),
    .btb_update_in              (btb_update_in),
    .btb_update_pc_in           (btb_update_pc_in),
    .btb_update_target_in       (btb_update_target_in),
    .btb_update_taken_in        (btb_update_taken_in),
    .ibus                       (ibus),
    .valid_out                  (valid_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .dbg_state                  (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state. exp_q holds the parked {pc, instr, taken} packet.
  logic [63:0]  m_pc;
  logic [128:0] exp_q[$];
  logic         m_valid, m_pt;
  logic [63:0]  m_out_pc, m_out_instr;
  bit           bv[BTB_N];
  logic [63:0]  btag[BTB_N], btgt[BTB_N];
  int           bcnt[BTB_N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0;
    exp_q.delete();
    m_valid = 1'b0; m_pt = 1'b0; m_out_pc = 64'h0; m_out_instr = NOP;
    for (int i = 0; i < BTB_N; i++) begin
      bv[i] = 1'b0; btag[i] = '0; btgt[i] = '0; bcnt[i] = 1;
    end
  endtask

  task automatic m_bubble();
    m_valid = 1'b0; m_out_instr = NOP; m_pt = 1'b0;
  endtask

  task automatic m_load(input logic [63:0] pc, input logic [63:0] instr, input logic pt);
    m_valid = 1'b1; m_out_pc = pc; m_out_instr = instr; m_pt = pt;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int          ix, ux;
    bit          pt;
    logic [63:0] npc, utag;
    logic [128:0] e;
    ix  = int'((m_pc >> 3) % BTB_N);
    pt  = bv[ix] && (btag[ix] == (m_pc >> (3 + LOG_N))) && (bcnt[ix] >= 2);
    npc = pt ? btgt[ix] : m_pc + 64'd8;
    if (redirect_in) begin
      m_pc = redirect_pc_in;
      exp_q.delete();
      if (!stall_in) m_bubble();
    end else if (exp_q.size() == 0) begin
      if (ibus.ibus_ack_in) begin
        if (stall_in) exp_q.push_back({m_pc, ibus.ibus_rdata_in, pt});
        else if (flush_in) m_bubble();
        else m_load(m_pc, ibus.ibus_rdata_in, pt);
        m_pc = npc;
      end else if (!stall_in) m_bubble();
    end else if (!stall_in) begin
      e = exp_q.pop_front();
      if (flush_in) m_bubble();
      else m_load(e[128:65], e[64:1], e[0]);
    end
    if (btb_update_in) begin
      ux   = int'((btb_update_pc_in >> 3) % BTB_N);
      utag = btb_update_pc_in >> (3 + LOG_N);
      if (bv[ux] && btag[ux] == utag) begin
        if (btb_update_taken_in) begin
          bcnt[ux] = (bcnt[ux] < 3) ? bcnt[ux] + 1 : 3;
          btgt[ux] = btb_update_target_in;
        end else bcnt[ux] = (bcnt[ux] > 0) ? bcnt[ux] - 1 : 0;
      end else begin
        bv[ux] = 1'b1; btag[ux] = utag; btgt[ux] = btb_update_target_in;
        bcnt[ux] = btb_update_taken_in ? 2 : 1;
      end
    end
  endtask

  task automatic idle();
    stall_in = 1'b0; flush_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
    btb_update_in = 1'b0; btb_update_pc_in = '0; btb_update_target_in = '0;
    btb_update_taken_in = 1'b0; ibus.ibus_ack_in = 1'b0; ibus.ibus_rdata_in = '0;
  endtask

  // One clock: check bus outputs, step the model, then check registered outputs.
  task automatic tick();
    #1;
    chk("ibus_req", ibus.ibus_req_out, (exp_q.size() == 0));
    chk("ibus_addr", ibus.ibus_addr_out, m_pc);
    model_step();
    @(posedge clk); #1;
    chk("valid_out", valid_out, m_valid);
    chk("pc_out", pc_out, m_out_pc);
    chk("instr_out", instr_out, m_out_instr);
    chk("pred_taken", branch_predicted_taken_out, m_pt);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1 chk("rst_req", ibus.ibus_req_out, 1'b0);
    @(posedge clk); #1;
    chk("rst_req_edge", ibus.ibus_req_out, 1'b0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pred", branch_predicted_taken_out, 1'b0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic fetch_at(input logic [63:0] pc);
    idle(); redirect_in = 1'b1; redirect_pc_in = pc; tick();
  endtask

  task automatic btb_upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk);
    idle(); btb_update_in = 1'b1; btb_update_pc_in = pc;
    btb_update_target_in = tgt; btb_update_taken_in = tk; tick();
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Sequential fetch from reset with ack held high.
    for (int i = 0; i < 2; i++) begin
      idle(); ibus.ibus_ack_in = 1'b1; ibus.ibus_rdata_in = 64'hA000 + 64'(i); tick();
    end
    chk("seq_addr_0x10", ibus.ibus_addr_out, 64'h10);
    chk("seq_pc_out_8", pc_out, 64'h8);

    // Ack at 0x10 under a 3-cycle stall, then release.
    idle(); stall_in = 1'b1; ibus.ibus_ack_in = 1'b1; ibus.ibus_rdata_in = 64'hCAFE_0010; tick();
    chk("hold_req_low", ibus.ibus_req_out, 1'b0);
    for (int i = 0; i < 2; i++) begin idle(); stall_in = 1'b1; tick(); end
    idle(); tick();
    chk("hold_pc_out", pc_out, 64'h10);
    chk("hold_instr", instr_out, 64'hCAFE_0010);
    chk("hold_next_addr", ibus.ibus_addr_out, 64'h18);

    // Redirect while parked and stalled, with a same-cycle ack.
    idle(); stall_in = 1'b1; ibus.ibus_ack_in = 1'b1; ibus.ibus_rdata_in = 64'hBEEF; tick();
    idle(); stall_in = 1'b1; ibus.ibus_ack_in = 1'b1; redirect_in = 1'b1;
    redirect_pc_in = 64'h400; tick();
    chk("redir_addr", ibus.ibus_addr_out, 64'h400);
    idle(); tick();
    chk("redir_bubble_valid", valid_out, 1'b0);
    chk("redir_bubble_instr", instr_out, NOP);

    // BTB training on 0x20 -> 0x80.
    btb_upd(64'h20, 64'h80, 1'b1);
    btb_upd(64'h20, 64'h80, 1'b1);
    fetch_at(64'h20);
    idle(); ibus.ibus_ack_in = 1'b1; ibus.ibus_rdata_in = 64'h2020; tick();
    chk("btb_taken_addr", ibus.ibus_addr_out, 64'h80);
    chk("btb_taken_pred", branch_predicted_taken_out, 1'b1);
    btb_upd(64'h20, 64'h0, 1'b0);
    fetch_at(64'h20);
    idle(); ibus.ibus_ack_in = 1'b1; tick();
    chk("btb_weak_addr", ibus.ibus_addr_out, 64'h80);
    btb_upd(64'h20, 64'h0, 1'b0);
    fetch_at(64'h20);
    idle(); ibus.ibus_ack_in = 1'b1; tick();
    chk("btb_nt_addr", ibus.ibus_addr_out, 64'h28);
    chk("btb_nt_pred", branch_predicted_taken_out, 1'b0);

    // Flush with ack at 0x30.
    fetch_at(64'h30);
    idle(); ibus.ibus_ack_in = 1'b1; flush_in = 1'b1; ibus.ibus_rdata_in = 64'h3030; tick();
    chk("flush_valid", valid_out, 1'b0);
    chk("flush_instr", instr_out, NOP);
    chk("flush_next_addr", ibus.ibus_addr_out, 64'h38);

    // Two cycles without ack.
    for (int i = 0; i < 2; i++) begin idle(); tick(); end
    chk("noack_addr", ibus.ibus_addr_out, 64'h38);

    // PC wraps modulo 2^64.
    fetch_at(64'hFFFF_FFFF_FFFF_FFF8);
    idle(); ibus.ibus_ack_in = 1'b1; tick();
    chk("wrap_addr", ibus.ibus_addr_out, 64'h0);

    // Reset while parked.
    idle(); stall_in = 1'b1; ibus.ibus_ack_in = 1'b1; ibus.ibus_rdata_in = 64'h5555; tick();
    do_reset();
    idle(); tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      stall_in         = ($urandom_range(0, 3) == 0);
      flush_in         = ($urandom_range(0, 9) == 0);
      redirect_in      = ($urandom_range(0, 11) == 0);
      redirect_pc_in   = 64'($urandom_range(0, 31)) << 3;
      ibus.ibus_ack_in = ($urandom_range(0, 3) != 0);
      ibus.ibus_rdata_in = {$urandom, $urandom};
      btb_update_in    = ($urandom_range(0, 4) == 0);
      btb_update_pc_in = 64'($urandom_range(0, 31)) << 3;
      btb_update_target_in = 64'($urandom_range(0, 31)) << 3;
      btb_update_taken_in  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
